// File: rtl/predec_class_sched.sv
// Dispatch scheduler: buffers predecoded instructions and steers one per cycle
// to four credit-limited execution ports; system instructions drain all ports first.
//
// state | meaning
// RUN   | normal issue from queue head
// DRAIN | head is sys; wait until every port has all credits back
// SYS   | sys instruction issued; wait for sys_done
module predec_class_sched #(
    parameter int DEPTH = 4,
    parameter int CRED  = 3,
    parameter int TAG_W = 6
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_vld,
    input  logic [12:0]      in_class,
    input  logic [TAG_W-1:0] in_tag,
    output logic             in_rdy,
    input  logic             flush,
    input  logic [3:0]       credit_ret,
    input  logic             sys_done,
    output logic [3:0]       out_vld,
    output logic [TAG_W-1:0] out_tag,
    output logic             out_sys_vld,
    output logic             cred_err
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = $clog2(CRED + 1);

    typedef enum logic [1:0] {RUN, DRAIN, SYS} state_t;

    state_t           state, stateNext;
    logic [PW:0]      wrPtr, rdPtr;
    logic [12:0]      classMem [DEPTH];
    logic [TAG_W-1:0] tagMem [DEPTH];
    logic [CW-1:0]    cred [4];

    logic             full, empty, push, pop, sysPop, isSys, targetHasCred, allFull;
    logic [12:0]      headClass;
    logic [TAG_W-1:0] headTag;
    logic [3:0]       target, issue, credNonZero, credMax;
    logic             unusedClassBits;

    assign full  = (wrPtr[PW] != rdPtr[PW]) && (wrPtr[PW-1:0] == rdPtr[PW-1:0]);
    assign empty = (wrPtr == rdPtr);
    assign in_rdy = !full;
    assign push = in_vld && !full && !flush;

    assign headClass = classMem[rdPtr[PW-1:0]];
    assign headTag   = tagMem[rdPtr[PW-1:0]];
    assign isSys     = headClass[10];
    assign unusedClassBits = ^headClass[12:11];

    always_comb begin
        for (int p = 0; p < 4; p++) begin
            credNonZero[p] = (cred[p] != '0);
            credMax[p]     = (cred[p] == CW'(CRED));
        end
    end
    assign allFull = &credMax;

    // First match wins; plain alu balances between the two ALU-capable ports.
    always_comb begin
        target = 4'b0000;
        if (headClass[1] || headClass[0])
            target = 4'b0010;
        else if (headClass[5] || headClass[9])
            target = 4'b0100;
        else if (headClass[6] || headClass[7])
            target = 4'b1000;
        else if (headClass[4] || headClass[3] || headClass[8])
            target = 4'b0001;
        else if (headClass[2])
            target = (cred[0] >= cred[1]) ? 4'b0001 : 4'b0010;
    end
    assign targetHasCred = |(target & credNonZero);

    always_comb begin
        stateNext = state;
        issue     = 4'b0000;
        pop       = 1'b0;
        sysPop    = 1'b0;
        case (state)
            RUN: begin
                if (!empty) begin
                    if (isSys) begin
                        stateNext = DRAIN;
                    end else if (target == 4'b0000) begin
                        pop = 1'b1;
                    end else if (targetHasCred) begin
                        issue = target;
                        pop   = 1'b1;
                    end
                end
            end
            DRAIN: begin
                if (allFull) begin
                    stateNext = SYS;
                    pop       = 1'b1;
                    sysPop    = 1'b1;
                end
            end
            SYS: begin
                if (sys_done) stateNext = RUN;
            end
            default: stateNext = RUN;
        endcase
        if (flush) begin
            stateNext = RUN;
            issue     = 4'b0000;
            pop       = 1'b0;
            sysPop    = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= RUN;
            wrPtr <= '0;
            rdPtr <= '0;
        end else begin
            state <= stateNext;
            if (flush) begin
                wrPtr <= '0;
                rdPtr <= '0;
            end else begin
                wrPtr <= wrPtr + (PW+1)'(push);
                rdPtr <= rdPtr + (PW+1)'(pop);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (push) begin
            classMem[wrPtr[PW-1:0]] <= in_class;
            tagMem[wrPtr[PW-1:0]]   <= in_tag;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            out_vld     <= 4'b0000;
            out_sys_vld <= 1'b0;
            out_tag     <= '0;
        end else begin
            out_vld     <= issue;
            out_sys_vld <= sysPop;
            if ((issue != 4'b0000) || sysPop) out_tag <= headTag;
        end
    end

    // Issue only happens with credit > 0, so the decrement never underflows.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int p = 0; p < 4; p++) cred[p] <= CW'(CRED);
            cred_err <= 1'b0;
        end else begin
            for (int p = 0; p < 4; p++) begin
                if (issue[p] && !credit_ret[p]) begin
                    cred[p] <= cred[p] - CW'(1);
                end else if (!issue[p] && credit_ret[p]) begin
                    if (credMax[p]) cred_err <= 1'b1;
                    else            cred[p]  <= cred[p] + CW'(1);
                end
            end
        end
    end

endmodule

// File: tb/tb_predec_class_sched.sv
// Directed scoreboard bench for predec_class_sched: expected issues are queued by
// the stimulus and popped by a monitor whenever the DUT pulses an output.
module tb_predec_class_sched;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        in_vld = 1'b0;
    logic [12:0] in_class = '0;
    logic [5:0]  in_tag = '0;
    logic        in_rdy;
    logic        flush = 1'b0;
    logic [3:0]  credit_ret = '0;
    logic        sys_done = 1'b0;
    logic [3:0]  out_vld;
    logic [5:0]  out_tag;
    logic        out_sys_vld;
    logic        cred_err;

    int nCmp = 0;
    int nErr = 0;
    logic [10:0] expQ[$];
    logic [10:0] monExp;

    predec_class_sched #(.DEPTH(4), .CRED(3), .TAG_W(6)) dut (
        .clk(clk), .rst(rst), .in_vld(in_vld), .in_class(in_class), .in_tag(in_tag),
        .in_rdy(in_rdy), .flush(flush), .credit_ret(credit_ret), .sys_done(sys_done),
        .out_vld(out_vld), .out_tag(out_tag), .out_sys_vld(out_sys_vld), .cred_err(cred_err)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        nCmp++;
        if (act !== exp) begin
            nErr++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input int n);
        repeat (n) tick();
    endtask

    task automatic push(input logic [12:0] c, input logic [5:0] t);
        in_vld = 1'b1; in_class = c; in_tag = t;
        tick();
        in_vld = 1'b0; in_class = '0;
    endtask

    task automatic expIssue(input logic sys, input logic [3:0] p, input logic [5:0] t);
        expQ.push_back({sys, p, t});
    endtask

    task automatic ret(input logic [3:0] r, input int n);
        credit_ret = r;
        repeat (n) tick();
        credit_ret = 4'b0000;
    endtask

    // {sys, one-hot port, tag} of every issue pulse must match the next queued entry.
    always @(negedge clk) begin
        if (rst && (out_vld != 4'b0000 || out_sys_vld)) begin
            if (expQ.size() == 0) begin
                nCmp++;
                nErr++;
                $display("FAIL unexpected_issue: got sys=%0b vld=%b tag=%0d expected nothing",
                         out_sys_vld, out_vld, out_tag);
            end else begin
                monExp = expQ.pop_front();
                chk("issue", {21'b0, out_sys_vld, out_vld, out_tag}, {21'b0, monExp});
            end
        end
    end

    initial begin
        repeat (3) @(posedge clk);
        #1;
        chk("rst_out_vld", {28'b0, out_vld}, 0);
        chk("rst_sys_vld", {31'b0, out_sys_vld}, 0);
        chk("rst_out_tag", {26'b0, out_tag}, 0);
        chk("rst_cred_err", {31'b0, cred_err}, 0);
        rst = 1'b1;
        tick();
        chk("rst_in_rdy", {31'b0, in_rdy}, 1);

        // alu to P0 with one-cycle latency
        expIssue(0, 4'b0001, 6'd5);
        push(13'h004, 6'd5);
        chk("lat_early", {28'b0, out_vld}, 0);
        tick();
        chk("lat_issue", {22'b0, out_vld, out_tag}, {22'b0, 4'b0001, 6'd5});
        ret(4'b0001, 1);

        // four loads: third empties P2 credits, fourth waits for a return
        for (int i = 0; i < 3; i++) expIssue(0, 4'b0100, 6'(10 + i));
        for (int i = 0; i < 4; i++) push(13'h020, 6'(10 + i));
        idle(4);
        expIssue(0, 4'b0100, 6'd13);
        ret(4'b0100, 1);
        idle(2);
        ret(4'b0100, 3);

        // P3 starved: queue fills, 5th entry refused
        for (int i = 0; i < 3; i++) expIssue(0, 4'b1000, 6'(20 + i));
        for (int i = 0; i < 7; i++) push(13'h040, 6'(20 + i));
        idle(1);
        chk("full_rdy", {31'b0, in_rdy}, 0);
        push(13'h040, 6'd27);
        chk("full_rdy_hold", {31'b0, in_rdy}, 0);
        expIssue(0, 4'b1000, 6'd23);
        ret(4'b1000, 1);
        chk("rdy_after_ret", {31'b0, in_rdy}, 0);
        tick();
        chk("rdy_after_pop", {31'b0, in_rdy}, 1);
        for (int i = 0; i < 3; i++) expIssue(0, 4'b1000, 6'(24 + i));
        ret(4'b1000, 6);
        idle(2);

        // sys drains P0, then blocks the following alu until sys_done
        expIssue(0, 4'b0001, 6'd30);
        expIssue(0, 4'b0001, 6'd31);
        expIssue(1, 4'b0000, 6'd32);
        expIssue(0, 4'b0001, 6'd33);
        push(13'h010, 6'd30);
        push(13'h010, 6'd31);
        push(13'h400, 6'd32);
        push(13'h004, 6'd33);
        idle(3);
        chk("drain_hold", {30'b0, out_vld[0], out_sys_vld}, 0);
        ret(4'b0001, 2);
        idle(4);
        sys_done = 1'b1;
        tick();
        sys_done = 1'b0;
        idle(2);
        ret(4'b0001, 1);

        // alu balancing with cred0=1, and same-cycle issue+return on P1
        expIssue(0, 4'b0001, 6'd40);
        expIssue(0, 4'b0001, 6'd41);
        expIssue(0, 4'b0010, 6'd42);
        expIssue(0, 4'b0010, 6'd43);
        push(13'h010, 6'd40);
        push(13'h010, 6'd41);
        idle(2);
        in_vld = 1'b1; in_class = 13'h004; in_tag = 6'd42;
        tick();
        in_tag = 6'd43; credit_ret = 4'b0010;
        tick();
        in_vld = 1'b0; credit_ret = 4'b0000;
        idle(2);
        ret(4'b0010, 1);
        chk("no_err_p1", {31'b0, cred_err}, 0);
        ret(4'b0001, 2);
        chk("no_err_p0", {31'b0, cred_err}, 0);

        // overflow returns: P1 must be full again, then P0
        ret(4'b0010, 1);
        chk("err_set", {31'b0, cred_err}, 1);
        idle(3);
        ret(4'b0001, 1);
        chk("err_sticky", {31'b0, cred_err}, 1);

        // flush with sys held in DRAIN and three queued entries
        expIssue(0, 4'b0001, 6'd50);
        push(13'h010, 6'd50);
        push(13'h400, 6'd51);
        push(13'h004, 6'd52);
        push(13'h004, 6'd53);
        idle(2);
        in_vld = 1'b1; in_class = 13'h004; in_tag = 6'd54; flush = 1'b1;
        tick();
        in_vld = 1'b0; flush = 1'b0;
        chk("flush_rdy", {31'b0, in_rdy}, 1);
        chk("flush_no_vld", {28'b0, out_vld}, 0);
        chk("flush_err_kept", {31'b0, cred_err}, 1);
        expIssue(0, 4'b0010, 6'd55);
        push(13'h004, 6'd55);
        idle(3);
        ret(4'b0011, 1);
        idle(4);
        chk("expq_empty", expQ.size(), 0);

        // asynchronous reset while an issue pulse is visible
        expIssue(0, 4'b0001, 6'd60);
        push(13'h004, 6'd60);
        tick();
        @(negedge clk);
        #1;
        rst = 1'b0;
        #1;
        chk("arst_out_vld", {28'b0, out_vld}, 0);
        chk("arst_out_tag", {26'b0, out_tag}, 0);
        chk("arst_cred_err", {31'b0, cred_err}, 0);
        expQ.delete();
        tick();
        rst = 1'b1;
        tick();
        chk("arst_in_rdy", {31'b0, in_rdy}, 1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCmp, nErr);
        $finish;
    end

endmodule
